// File: rtl/cw_pkg.sv
// Shared widths, FSM encoding and saturating helper for the codeword encoder.
package cw_pkg;
  localparam int N_W = 11;
  localparam int T_W = 6;
  localparam int D_W = 10;
  localparam int U_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FLAG   = 3'd2,
    INDEX  = 3'd3,
    EMIT   = 3'd4,
    FIN    = 3'd5
  } state_t;

  // Unsigned subtraction clamped at zero so an overdrawn length ends the word.
  function automatic logic [N_W-1:0] sat_sub(input logic [N_W-1:0] a,
                                             input logic [N_W-1:0] b);
    return (b > a) ? '0 : (a - b);
  endfunction
endpackage

// File: rtl/cw_bit_shift.sv
// Serial collector for the u-bit index, MSB first.
module cw_bit_shift
  import cw_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           shift_en,
  input  logic           bit_in,
  input  logic [U_W-1:0] u,
  output logic [D_W-1:0] idx,
  output logic           last_bit
);
  logic [D_W-1:0] idx_q, idx_d;
  logic [U_W-1:0] cnt_q, cnt_d;

  // Next index/count: clear on a new index, shift in one bit per accepted bit.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (clr) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      idx_d = {idx_q[D_W-2:0], bit_in};
      cnt_d = cnt_q + U_W'(1);
    end
  end

  // Index and bit-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  // The bit about to be accepted is the last one of the index.
  assign last_bit = ((cnt_q + U_W'(1)) == u);
  assign idx      = idx_q;
endmodule

// File: rtl/cw_enc_ctrl.sv
// Constant-weight encoder control: walks the payload bits, queries best_d,
// and emits the positions of the one-bits of the codeword.
module cw_enc_ctrl
  import cw_pkg::*;
#(
  parameter int BD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n_init,
  input  logic [T_W-1:0] t_init,
  input  logic           bit_in,
  input  logic           bit_valid,
  output logic           bit_ready,
  output logic [N_W-1:0] bd_n,
  output logic [T_W-1:0] bd_t,
  input  logic [D_W-1:0] bd_d,
  input  logic [U_W-1:0] bd_u,
  output logic [N_W-1:0] pos,
  output logic           pos_valid,
  input  logic           pos_ready,
  output logic           busy,
  output logic           done,
  output logic [T_W-1:0] t_left
);
  localparam logic [7:0] LAT_C = 8'(BD_LAT);

  state_t         state_q, state_d;
  logic [N_W-1:0] n_q, n_d, delta_q, delta_d, bd_n_q, bd_n_d;
  logic [T_W-1:0] t_q, t_d, bd_t_q, bd_t_d, t_left_q, t_left_d;
  logic [D_W-1:0] d_q, d_d;
  logic [U_W-1:0] u_q, u_d;
  logic [7:0]     lat_q, lat_d;
  logic           clr, shift_en, last_bit;
  logic [D_W-1:0] idx;

  cw_bit_shift u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .u        (u_q),
    .idx      (idx),
    .last_bit (last_bit)
  );

  // Next-state and datapath updates for the encoding walk.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    t_d      = t_q;
    delta_d  = delta_q;
    d_d      = d_q;
    u_d      = u_q;
    lat_d    = lat_q;
    bd_n_d   = bd_n_q;
    bd_t_d   = bd_t_q;
    t_left_d = t_left_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_init;
          t_d     = t_init;
          delta_d = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lat_q == 8'd0 && (t_q == '0 || n_q <= N_W'(t_q))) begin
          t_left_d = t_q;
          state_d  = FIN;
        end else if (lat_q == LAT_C) begin
          d_d     = bd_d;
          u_d     = bd_u;
          state_d = FLAG;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      FLAG: begin
        if (bit_valid) begin
          if (bit_in) begin
            n_d     = sat_sub(n_q, N_W'(d_q));
            delta_d = delta_q + N_W'(d_q);
            state_d = LOOKUP;
          end else begin
            clr     = 1'b1;
            state_d = (u_q == '0) ? EMIT : INDEX;
          end
        end
      end
      INDEX: begin
        if (bit_valid) begin
          shift_en = 1'b1;
          if (last_bit) state_d = EMIT;
        end
      end
      EMIT: begin
        if (pos_ready) begin
          delta_d = delta_q + N_W'(idx) + N_W'(1);
          n_d     = sat_sub(n_q, N_W'(idx) + N_W'(1));
          t_d     = t_q - T_W'(1);
          state_d = LOOKUP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Present the query to best_d from the first LOOKUP cycle and hold it there.
    if (state_d == LOOKUP && state_q != LOOKUP) begin
      lat_d  = 8'd0;
      bd_n_d = n_d;
      bd_t_d = t_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      t_q      <= '0;
      delta_q  <= '0;
      d_q      <= '0;
      u_q      <= '0;
      lat_q    <= '0;
      bd_n_q   <= '0;
      bd_t_q   <= '0;
      t_left_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      t_q      <= t_d;
      delta_q  <= delta_d;
      d_q      <= d_d;
      u_q      <= u_d;
      lat_q    <= lat_d;
      bd_n_q   <= bd_n_d;
      bd_t_q   <= bd_t_d;
      t_left_q <= t_left_d;
    end
  end

  assign bit_ready = (state_q == FLAG) || (state_q == INDEX);
  assign pos_valid = (state_q == EMIT);
  assign pos       = pos_valid ? (delta_q + N_W'(idx)) : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign bd_n      = bd_n_q;
  assign bd_t      = bd_t_q;
  assign t_left    = t_left_q;
endmodule

// File: tb/tb_cw_enc_ctrl.sv
// Scoreboard bench for cw_enc_ctrl with a one-cycle behavioural best_d.
module tb_cw_enc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] n_init = '0;
  logic [5:0]  t_init = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [10:0] bd_n;
  logic [5:0]  bd_t;
  logic [9:0]  bd_d;
  logic [3:0]  bd_u;
  logic [10:0] pos;
  logic        pos_valid;
  logic        pos_ready = 1'b1;
  logic        busy, done;
  logic [5:0]  t_left;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int consumed = 0;
  int hs_cnt = 0;
  int exp_pos[$];
  int exp_tl[$];
  logic        stall_prev = 1'b0;
  logic [10:0] stall_pos = '0;

  cw_enc_ctrl #(.BD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_init(n_init), .t_init(t_init),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bd_n(bd_n), .bd_t(bd_t), .bd_d(bd_d), .bd_u(bd_u),
    .pos(pos), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .busy(busy), .done(done), .t_left(t_left)
  );

  always #5 clk = ~clk;

  // Behavioural best_d with one cycle of latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd_d <= '0;
      bd_u <= '0;
    end else if (bd_n == 11'd1024 && bd_t == 6'd1) begin
      bd_d <= 10'd512;
      bd_u <= 4'd9;
    end else if (bd_n == 11'd512 && bd_t == 6'd1) begin
      bd_d <= 10'd256;
      bd_u <= 4'd8;
    end else begin
      bd_d <= 10'd1;
      bd_u <= 4'd0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops expectations on each pos handshake and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pos_valid && pos_ready) begin
        hs_cnt++;
        if (exp_pos.size() == 0) check("pos_unexpected", int'(pos), -1);
        else check("pos", int'(pos), exp_pos.pop_front());
        stall_prev = 1'b0;
      end else if (pos_valid) begin
        if (stall_prev) check("pos_stable", int'(pos), int'(stall_pos));
        stall_prev = 1'b1;
        stall_pos  = pos;
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        if (exp_tl.size() == 0) check("done_unexpected", int'(t_left), -1);
        else check("t_left", int'(t_left), exp_tl.pop_front());
      end
      if (bit_valid && bit_ready) consumed++;
    end
  end

  task automatic do_start(input int n, input int t);
    @(posedge clk); #1;
    start  = 1'b1;
    n_init = 11'(n);
    t_init = 6'(t);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer nb bits MSB first, one per cycle whenever the DUT is ready.
  task automatic send_bits(input logic [15:0] bits, input int nb);
    int k = nb - 1;
    int guard = 0;
    while (k >= 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
      if (bit_ready) begin
        bit_valid = 1'b1;
        bit_in    = bits[k];
        k--;
      end else begin
        bit_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    bit_valid = 1'b0;
    if (k >= 0) check("bit_timeout", k, -1);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    logic seen = 1'b0;
    while (!seen && c < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      c++;
    end
    check("done_seen", int'(seen), 1);
  endtask

  initial begin
    int c0, h0, c;
    logic bad;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_bit_ready", int'(bit_ready), 0);
    check("rst_bd_n", int'(bd_n), 0);
    check("rst_t_left", int'(t_left), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Flag 0, index 5
    exp_pos.push_back(5); exp_tl.push_back(0);
    c0 = consumed;
    do_start(1024, 1);
    @(negedge clk);
    check("bd_n_lookup", int'(bd_n), 1024);
    check("bd_t_lookup", int'(bd_t), 1);
    send_bits(16'b0_000000101, 10);
    wait_done(40);
    check("bits_w1", consumed - c0, 10);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Flag 1 then flag 0, index 3 with delta 512
    exp_pos.push_back(515); exp_tl.push_back(0);
    do_start(1024, 1);
    send_bits(16'b1_0_00000011, 10);
    wait_done(40);

    // Output back-pressure for five cycles
    exp_pos.push_back(5); exp_tl.push_back(0);
    c0 = consumed; h0 = hs_cnt;
    pos_ready = 1'b0;
    do_start(1024, 1);
    send_bits(16'b0_000000101, 10);
    bit_valid = 1'b1; bit_in = 1'b1;
    c = 0;
    while (!pos_valid && c < 20) begin @(posedge clk); #1; c++; end
    check("pos_valid_seen", int'(pos_valid), 1);
    repeat (5) @(posedge clk);
    #1 pos_ready = 1'b1;
    wait_done(20);
    bit_valid = 1'b0;
    check("bits_stall", consumed - c0, 10);
    check("hs_stall", hs_cnt - h0, 1);

    // Immediate termination: t=0, then n<=t
    c0 = consumed;
    bit_valid = 1'b1; bit_in = 1'b0;
    exp_tl.push_back(0);
    do_start(1024, 0);
    wait_done(3);
    exp_tl.push_back(6);
    do_start(6, 6);
    wait_done(3);
    bit_valid = 1'b0;
    check("bits_term", consumed - c0, 0);

    // Reset in the middle of the index
    do_start(1024, 1);
    send_bits(16'b0000, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(bit_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pos_valid || done || busy) bad = 1'b1;
    end
    check("post_rst_quiet", int'(bad), 0);

    // Clean word after reset; a second start while busy is ignored
    exp_pos.push_back(5); exp_tl.push_back(0);
    do_start(1024, 1);
    do_start(6, 6);
    send_bits(16'b0_000000101, 10);
    wait_done(40);

    repeat (3) @(negedge clk);
    check("exp_pos_left", exp_pos.size(), 0);
    check("exp_tl_left", exp_tl.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
